// File: rtl/pram_fifo.sv
// Command FIFO between CPU and Painter.
// Packs halfword pairs into 32-bit line commands and queues them.
module pram_fifo #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_wdata,
    input  logic              flush,
    input  logic              re,
    output logic [31:0]       PRAMdata,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              half_pending,
    output logic              overflow,
    output logic              underflow
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HALF = 1'b1
    } asm_state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [15:0]     LP_SWAP  = 16'hFFFF;

    asm_state_t        r_state;
    asm_state_t        w_state_nxt;
    logic [15:0]       r_hi;
    logic [31:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_data;
    logic              r_ovf;
    logic              r_udf;

    logic              w_push_req;
    logic              w_load_hi;
    logic [31:0]       w_push_word;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_udf;

    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_pop   = re & ~w_empty & ~flush;
    assign w_udf   = re & w_empty & ~flush;
    // A full queue still accepts a push when a pop frees a slot this cycle
    assign w_push  = w_push_req & (~w_full | w_pop);
    assign w_drop  = w_push_req & ~w_push;

    // Assembler state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Assembler next state; FFFF in HALF is ordinary low data
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else if (cpu_we) begin
            unique case (r_state)
                S_IDLE: begin
                    if (cpu_wdata != LP_SWAP) begin
                        w_state_nxt = S_HALF;
                    end
                end
                S_HALF: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Assembler outputs: push request, hi capture and the word to queue
    always_comb begin
        w_push_req  = 1'b0;
        w_load_hi   = 1'b0;
        w_push_word = {r_hi, cpu_wdata};
        if (cpu_we && !flush) begin
            unique case (r_state)
                S_IDLE: begin
                    if (cpu_wdata == LP_SWAP) begin
                        w_push_req  = 1'b1;
                        w_push_word = 32'hFFFF_FFFF;
                    end else begin
                        w_load_hi = 1'b1;
                    end
                end
                S_HALF: begin
                    w_push_req = 1'b1;
                end
                default: begin
                    w_push_req = 1'b0;
                end
            endcase
        end
    end

    // High halfword holding register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi <= '0;
        end else if (w_load_hi) begin
            r_hi <= cpu_wdata;
        end
    end

    // Storage array; contents need no reset since count guards reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_word;
        end
    end

    // Pointers and occupancy counter
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Read data register; holds across flush and empty reads
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data <= '0;
        end else if (w_pop) begin
            r_data <= r_mem[r_rptr];
        end
    end

    // Sticky error flags
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_udf) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign PRAMdata     = r_data;
    assign empty        = w_empty;
    assign full         = w_full;
    assign count        = r_count;
    assign half_pending = (r_state == S_HALF);
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_pram_fifo.sv
// Bench for pram_fifo: queue-based reference model,
// scoreboard of read data checked by an independent monitor.
module tb_pram_fifo;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_we;
    logic [15:0]       cpu_wdata;
    logic              flush;
    logic              re;
    logic [31:0]       PRAMdata;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              half_pending;
    logic              overflow;
    logic              underflow;

    pram_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .reset(reset),
        .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata),
        .flush(flush),
        .re(re),
        .PRAMdata(PRAMdata),
        .empty(empty),
        .full(full),
        .count(count),
        .half_pending(half_pending),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic [31:0] exp_q[$];
    bit          m_pend;
    logic [15:0] m_hi;
    bit          m_ovf;
    bit          m_udf;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_pend = 0;
        m_hi   = '0;
        m_ovf  = 0;
        m_udf  = 0;
        m_data = '0;
    endtask

    // Effect of one clock edge with the given inputs
    task automatic model_edge(input bit we, input logic [15:0] wd,
                              input bit r, input bit fl);
        int          n0;
        bit          popped;
        bit          has;
        logic [31:0] item;
        if (fl) begin
            m_q.delete();
            m_pend = 0;
            m_ovf  = 0;
            m_udf  = 0;
            return;
        end
        n0     = m_q.size();
        popped = r && (n0 > 0);
        if (popped) begin
            m_data = m_q.pop_front();
            exp_q.push_back(m_data);
        end else if (r) begin
            m_udf = 1;
        end
        has  = 0;
        item = '0;
        if (we) begin
            if (m_pend) begin
                item   = {m_hi, wd};
                has    = 1;
                m_pend = 0;
            end else if (wd == 16'hFFFF) begin
                item = 32'hFFFF_FFFF;
                has  = 1;
            end else begin
                m_hi   = wd;
                m_pend = 1;
            end
        end
        if (has) begin
            if (n0 < DEPTH || popped) m_q.push_back(item);
            else m_ovf = 1;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(m_q.size() == DEPTH));
        chk({tag, ".half"}, 32'(half_pending), 32'(m_pend));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
        chk({tag, ".data"}, PRAMdata, m_data);
    endtask

    task automatic step(input bit we, input logic [15:0] wd,
                        input bit r, input bit fl, input string tag);
        @(negedge clk);
        cpu_we    = we;
        cpu_wdata = wd;
        re        = r;
        flush     = fl;
        model_edge(we, wd, r, fl);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0, "idle");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        cpu_we = 1'b0;
        re     = 1'b0;
        flush  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: every accepted read must deliver the scoreboard head
    always @(posedge clk) begin
        if (reset && !flush && re && !empty) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon.unexpected_read: got %h expected none",
                         PRAMdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                checks--;
                chk("mon.read", PRAMdata, e);
            end
        end
    end

    initial begin
        reset     = 1'b0;
        cpu_we    = 1'b0;
        cpu_wdata = '0;
        flush     = 1'b0;
        re        = 1'b0;
        do_reset();

        // Basic pair then read
        step(1, 16'h0123, 0, 0, "pair.hi");
        chk("pair.half1", 32'(half_pending), 32'd1);
        step(1, 16'h4567, 0, 0, "pair.lo");
        chk("pair.cnt1", 32'(count), 32'd1);
        step(0, 16'h0, 1, 0, "pair.re");
        chk("pair.data", PRAMdata, 32'h0123_4567);
        chk("pair.cnt0", 32'(count), 32'd0);

        // Swap token, then FFFF as low half
        step(1, 16'hFFFF, 0, 0, "swap.w");
        chk("swap.cnt", 32'(count), 32'd1);
        step(0, 16'h0, 1, 0, "swap.re");
        chk("swap.data", PRAMdata, 32'hFFFF_FFFF);
        step(1, 16'h0001, 0, 0, "lo_ff.hi");
        step(1, 16'hFFFF, 0, 0, "lo_ff.lo");
        step(0, 16'h0, 1, 0, "lo_ff.re");
        chk("lo_ff.data", PRAMdata, 32'h0001_FFFF);

        // Fill, overflow, drain; twice to wrap pointers
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DEPTH; i++) begin
                step(1, 16'(pass), 0, 0, "fill.hi");
                step(1, 16'(i), 0, 0, "fill.lo");
            end
            chk("fill.full", 32'(full), 32'd1);
            step(1, 16'hAAAA, 0, 0, "ovf.hi");
            step(1, 16'h5555, 0, 0, "ovf.lo");
            chk("ovf.flag", 32'(overflow), 32'd1);
            chk("ovf.cnt", 32'(count), 32'd64);
            for (int i = 0; i < DEPTH; i++) begin
                step(0, 16'h0, 1, 0, "drain");
                chk("drain.data", PRAMdata, {16'(pass), 16'(i)});
            end
            step(0, 16'h0, 0, 1, "fill.flush");
        end

        // Simultaneous push/pop with count==1
        step(1, 16'h1111, 0, 0, "sim1.a");
        step(1, 16'h2222, 0, 0, "sim1.b");
        step(1, 16'h3333, 0, 0, "sim1.c");
        step(1, 16'h4444, 1, 0, "sim1.d");
        chk("sim1.cnt", 32'(count), 32'd1);
        chk("sim1.old", PRAMdata, 32'h1111_2222);
        step(0, 16'h0, 1, 0, "sim1.e");

        // Simultaneous push/pop while full
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 16'h00F0, 0, 0, "fsim.hi");
            step(1, 16'(i), 0, 0, "fsim.lo");
        end
        step(1, 16'hBEEF, 0, 0, "fsim.p1");
        step(1, 16'hCAFE, 1, 0, "fsim.p2");
        chk("fsim.ovf", 32'(overflow), 32'd0);
        chk("fsim.cnt", 32'(count), 32'd64);
        for (int i = 0; i < DEPTH; i++) step(0, 16'h0, 1, 0, "fsim.drain");

        // Underflow, then flush with a pending half
        step(0, 16'h0, 1, 0, "udf");
        chk("udf.flag", 32'(underflow), 32'd1);
        chk("udf.hold", PRAMdata, 32'hBEEF_CAFE);
        step(1, 16'h7777, 0, 0, "fl.hi");
        step(1, 16'h8888, 1, 1, "fl.flush");
        chk("fl.half", 32'(half_pending), 32'd0);
        chk("fl.udf", 32'(underflow), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          we;
            bit          r;
            bit          fl;
            logic [15:0] wd;
            we = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 40);
            fl = ($urandom_range(0, 999) < 5);
            wd = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
            step(we, wd, r, fl, "rnd");
        end

        // Reset mid-pair clears data and pending half
        step(1, 16'h1234, 0, 0, "rst.hi");
        idle(1);
        do_reset();
        idle(2);
        chk("end.sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
